bus_copy_master: RTL and testbench

//  Bus initiator (DMA) for the 6502-style memory bus: RW=1 read / RW=0 write, 16-bit AD.

---
 rtl/bus_copy_master.sv | 182 ++++++++++++++++++
 tb/tb_bus_copy_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_copy_master.sv
// ---------------------------------------------------------------------------
// bus_copy_master
//   Byte-wise block copy initiator for a 6502-style memory bus (RW=1 read,
//   RW=0 write). Copies len bytes from src to dst in ascending address order,
//   one byte per READ/LATCH/WRITE sequence, against a synchronous RAM that
//   returns read data one clock after it samples the read address.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   start      in   launch a copy (IDLE only), captures src/dst/len
//   src        in   first source address
//   dst        in   first destination address
//   len        in   byte count, 0 = no bus cycles
//   abort      in   cancel a copy in progress, no done pulse
//   bus_grant  in   arbiter grant, low stalls the sequence
//   busy       out  copy in progress
//   done       out  one-cycle pulse on normal completion
//   RW         out  1 = read, 0 = write
//   AD         out  bus address
//   D_out      out  write data
//   D_in       in   read data, valid the cycle after the read is sampled
//
// States
//   state  | meaning
//   IDLE   | waiting for start, bus parked at read of address 0
//   READ   | presenting source address to the RAM
//   LATCH  | same address held, RAM data valid, captured on grant
//   WRITE  | presenting destination address and data, write on grant
//   FIN    | done pulse, back to IDLE
// ---------------------------------------------------------------------------
module bus_copy_master #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              bus_grant,
    output logic              busy,
    output logic              done,
    output logic              RW,
    output logic [ADDR_W-1:0] AD,
    output logic [7:0]        D_out,
    input  logic [7:0]        D_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_WRITE,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [7:0]        data_q, data_d;

    logic [LEN_W-1:0]  idx_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // Address sums truncate to ADDR_W, so a copy running past the top of
    // memory wraps to address 0.
    assign idx_inc = idx_q + LEN_W'(1);
    assign rd_addr = src_q + ADDR_W'(idx_q);
    assign wr_addr = dst_q + ADDR_W'(idx_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                // start has priority over abort here; abort means nothing in IDLE
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    idx_d   = '0;
                    state_d = (len == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus_grant) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus_grant) begin
                    data_d  = D_in;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // A granted write is already on the bus this cycle, so it
                // completes even when abort arrives with it.
                if (bus_grant) begin
                    idx_d = idx_inc;
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (idx_inc == len_q) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_READ;
                    end
                end else if (abort) begin
                    state_d = S_IDLE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs decode from registered state; RW in WRITE follows grant
    // directly so no write is ever presented without the bus.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        RW   = 1'b1;
        AD   = '0;
        case (state_q)
            S_READ, S_LATCH: begin
                busy = 1'b1;
                AD   = rd_addr;
            end
            S_WRITE: begin
                busy = 1'b1;
                AD   = wr_addr;
                RW   = ~bus_grant;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign D_out = data_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// ---------------------------------------------------------------------------
// tb_bus_copy_master
//   Bench for bus_copy_master with a behavioural synchronous RAM. Expected
//   writes are queued when a copy is launched and matched against every
//   RW=0 cycle seen on the bus.
// ---------------------------------------------------------------------------
module tb_bus_copy_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        bus_grant;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        RW;
    logic [15:0] AD;
    logic [7:0]  D_out;
    logic [7:0]  D_in;

    always #5 clk = ~clk;

    bus_copy_master #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk       (clk),
        .reset     (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .abort     (abort),
        .bus_grant (bus_grant),
        .busy      (busy),
        .done      (done),
        .RW        (RW),
        .AD        (AD),
        .D_out     (D_out),
        .D_in      (D_in)
    );

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    // synchronous RAM: read data registered one clock after address sample
    always @(posedge clk) begin
        if (RW) D_in <= mem[AD];
        else    mem[AD] = D_out;
    end

    typedef struct {
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // every bus write must be expected, in order, and only with grant
    always @(negedge clk) begin
        if (!rst && !RW) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required none", AD, D_out);
            end else begin
                mon_w = exp_q.pop_front();
                chk("wr_addr", AD, mon_w.exp_addr);
                chk("wr_data", D_out, mon_w.exp_data);
            end
            chk("rw_needs_grant", bus_grant, 1);
        end
    end

    task automatic init_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = mem[i];
        end
        mem[16'h0010] = 8'h11; ref_mem[16'h0010] = 8'h11;
        mem[16'h0011] = 8'h22; ref_mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33; ref_mem[16'h0012] = 8'h33;
        mem[16'h0013] = 8'h44; ref_mem[16'h0013] = 8'h44;
    endtask

    // forward byte copy on the reference image; queues n writes
    task automatic push_expected(input logic [15:0] s, input logic [15:0] d, input int n);
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < n; i++) begin
            a = s + 16'(i);
            b = d + 16'(i);
            ref_mem[b] = ref_mem[a];
            exp_q.push_back('{b, ref_mem[b]});
        end
    endtask

    // called just after an edge; returns just after the accept edge E0
    task automatic start_copy(input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] l, input logic ab);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        abort = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] l;
        int          lo1;       // first cycle of a 5-cycle grant-low window, 0 = none
        int          lo2;
        int          exp_busy;
        int          exp_done_at;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input logic ab);
        int  busy_cnt;
        int  done_cnt;
        int  done_at;
        bit  finished;
        bit  low;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        finished = 0;
        init_mem();
        push_expected(v.s, v.d, int'(v.l));
        start_copy(v.s, v.d, v.l, ab);
        for (int c = 0; c < 400; c++) begin
            low = (v.lo1 > 0 && c >= v.lo1 && c < v.lo1 + 5) ||
                  (v.lo2 > 0 && c >= v.lo2 && c < v.lo2 + 5);
            bus_grant = ~low;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            @(posedge clk);
            #1;
            if (done_at >= 0 && c >= done_at + 2) begin
                finished = 1;
                break;
            end
        end
        bus_grant = 1'b1;
        chk("copy_finished", finished, 1);
        chk("busy_cycles", busy_cnt, v.exp_busy);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_at, v.exp_done_at);
        chk("pending_writes", exp_q.size(), 0);
        for (int i = 0; i < int'(v.l); i++) begin
            chk("mem_dst", mem[v.d + 16'(i)], ref_mem[v.d + 16'(i)]);
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;

        //             src       dst       len  lo1 lo2 busy done_at
        vecs[0] = '{16'h0010, 16'h0200, 16'd4, 0, 0, 12, 12};   // basic
        vecs[1] = '{16'h0040, 16'h0500, 16'd1, 0, 0,  3,  3};   // single byte
        vecs[2] = '{16'h0010, 16'h0200, 16'd0, 0, 0,  0,  0};   // len 0
        vecs[3] = '{16'hFFFE, 16'h0100, 16'd3, 0, 0,  9,  9};   // source wrap
        vecs[4] = '{16'h0300, 16'h0301, 16'd3, 0, 0,  9,  9};   // overlap replicate
        vecs[5] = '{16'h0010, 16'h0200, 16'd4, 1, 7, 22, 22};   // stall LATCH then WRITE

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        bus_grant = 1'b1;
        src       = '0;
        dst       = '0;
        len       = '0;
        init_mem();

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rw", RW, 1);
        chk("rst_ad", AD, 0);
        chk("rst_dout", D_out, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_rw", RW, 1);
        end
        @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], 1'b0);
        end

        // abort during READ of byte 2: only the first two bytes land
        init_mem();
        push_expected(16'h0010, 16'h0200, 2);
        start_copy(16'h0010, 16'h0200, 16'd8, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        dcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dcnt++;
            chk("abort_busy_after", busy, 0);
            @(posedge clk);
            #1;
        end
        chk("abort_done", dcnt, 0);
        chk("abort_pending", exp_q.size(), 0);
        chk("abort_mem200", mem[16'h0200], ref_mem[16'h0200]);
        chk("abort_mem201", mem[16'h0201], ref_mem[16'h0201]);
        chk("abort_mem202", mem[16'h0202], ref_mem[16'h0202]);
        exp_q.delete();

        // reset in the middle of byte 1 WRITE: RW drops back immediately
        init_mem();
        push_expected(16'h0010, 16'h0200, 1);
        start_copy(16'h0010, 16'h0200, 16'd8, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_rw", RW, 0);
        rst = 1'b1;
        #1;
        chk("reset_rw", RW, 1);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        chk("reset_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_pending", exp_q.size(), 0);
        chk("reset_mem201", mem[16'h0201], ref_mem[16'h0201]);
        exp_q.delete();

        // restart after reset, with abort alongside start (start wins)
        run_vec(vecs[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
